mmio_io_ctrl: RTL and testbench

//  Memory-mapped I/O controller downstream of the single-cycle CPU's data-memory stage.

---
 rtl/io_defs.sv | 40 ++++
 rtl/seven_seg_decoder.sv | 32 +++
 rtl/mmio_io_ctrl.sv | 156 +++++++++++++++
 tb/tb_mmio_io_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_defs.sv
// Shared I/O definitions for the memory-mapped I/O window at 0xF00000xx.
// The project top reuses these address constants and the KEY read layout.
package io_defs;

  localparam int DBITS = 32;

  localparam logic [DBITS-1:0] ADDR_HEX  = 32'hF000_0000;
  localparam logic [DBITS-1:0] ADDR_LEDR = 32'hF000_0004;
  localparam logic [DBITS-1:0] ADDR_LEDG = 32'hF000_0008;
  localparam logic [DBITS-1:0] ADDR_KEY  = 32'hF000_0010;
  localparam logic [DBITS-1:0] ADDR_SW   = 32'hF000_0014;

  localparam int NUM_KEYS       = 4;
  localparam int NUM_SW         = 10;
  localparam int NUM_INPUTS     = NUM_KEYS + NUM_SW;
  localparam int KEY_STICKY_LSB = 4;

  // Which I/O register an address selects.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_HEX,
    SEL_LEDR,
    SEL_LEDG,
    SEL_KEY,
    SEL_SW
  } io_sel_e;

  // Exact full-width compare: no aliasing inside the window.
  function automatic io_sel_e decode_addr(input logic [DBITS-1:0] a);
    case (a)
      ADDR_HEX:  return SEL_HEX;
      ADDR_LEDR: return SEL_LEDR;
      ADDR_LEDG: return SEL_LEDG;
      ADDR_KEY:  return SEL_KEY;
      ADDR_SW:   return SEL_SW;
      default:   return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}, glyphs 0-F.
module seven_seg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; every input value has an explicit pattern.
  always_comb begin
    // NOTE: combinational outputs get a default first so no path can infer a latch.
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller behind the CPU data-memory stage.
// Stores drive HEX/LEDR/LEDG registers; loads return synchronised, debounced
// KEY/SW state plus sticky key-press flags.
// Optional feature macro: IO_DEBOUNCE_EN (per-bit debounce counters). When it is
// undefined the debounced value is simply the synchroniser output.
module mmio_io_ctrl
  import io_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             io_hit,
  output logic [DBITS-1:0] rd_data,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG
);

  // Raw input vector is {SW, KEY}; KEY is active-low so its idle level is 1.
  localparam logic [NUM_INPUTS-1:0] RAW_IDLE = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};

  io_sel_e sel;

  logic [15:0] hex_reg;
  logic [9:0]  ledr_q;
  logic [7:0]  ledg_q;
  logic [3:0]  sticky;

  logic [NUM_INPUTS-1:0] meta_q;
  logic [NUM_INPUTS-1:0] sync_q;
  logic [NUM_INPUTS-1:0] synced;   // polarity-corrected: 1 = key pressed / switch up
  logic [NUM_INPUTS-1:0] db;       // debounced view
  logic [NUM_KEYS-1:0]   key_db_next;
  logic [NUM_KEYS-1:0]   key_rise;
  logic                  key_read;

  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data[DBITS-1:16];

  assign sel    = decode_addr(addr);
  assign io_hit = (sel != SEL_NONE);

  // Output registers: loaded by stores that hit their address.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      hex_reg <= '0;
      ledr_q  <= '0;
      ledg_q  <= '0;
    end else if (wr_en) begin
      case (sel)
        SEL_HEX:  hex_reg <= wr_data[15:0];
        SEL_LEDR: ledr_q  <= wr_data[9:0];
        SEL_LEDG: ledg_q  <= wr_data[7:0];
        default:  ;
      endcase
    end
  end

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

  seven_seg_decoder u_hex0 (.nibble(hex_reg[3:0]),   .seg(HEX0));
  seven_seg_decoder u_hex1 (.nibble(hex_reg[7:4]),   .seg(HEX1));
  seven_seg_decoder u_hex2 (.nibble(hex_reg[11:8]),  .seg(HEX2));
  seven_seg_decoder u_hex3 (.nibble(hex_reg[15:12]), .seg(HEX3));

  // Two-flop synchroniser for every asynchronous KEY/SW bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RAW_IDLE;
      sync_q <= RAW_IDLE;
    end else begin
      meta_q <= {SW, KEY};
      sync_q <= meta_q;
    end
  end

  assign synced = sync_q ^ RAW_IDLE;

`ifdef IO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]         cnt_q [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] db_q;
  logic [NUM_INPUTS-1:0] db_next;

  // A bit is accepted once it has differed from the debounced value for the full window.
  always_comb begin
    db_next = db_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if ((synced[i] != db_q[i]) && (cnt_q[i] == CNT_LAST)) db_next[i] = synced[i];
    end
  end

  // Per-bit stability counters and debounced state.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= '0;
      // NOTE: the counter array is small and must start from zero, so it is reset explicitly.
      for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_next;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if ((synced[i] == db_q[i]) || (cnt_q[i] == CNT_LAST)) cnt_q[i] <= '0;
        else                                                  cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign db          = db_q;
  assign key_db_next = db_next[NUM_KEYS-1:0];
`else
  // Without debouncing the synchroniser output is the debounced view; its next
  // value is what the first stage holds now.
  assign db          = synced;
  assign key_db_next = meta_q[NUM_KEYS-1:0] ^ RAW_IDLE[NUM_KEYS-1:0];
`endif

  assign key_rise = key_db_next & ~db[NUM_KEYS-1:0];
  assign key_read = rd_en && (sel == SEL_KEY);

  // Sticky press flags: a KEY load clears them, a same-edge press still sets.
  always_ff @(posedge clk) begin
    if (reset) sticky <= '0;
    else       sticky <= (key_read ? 4'b0000 : sticky) | key_rise;
  end

  // Zero-latency read mux from registered state.
  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_HEX:  rd_data[15:0] = hex_reg;
      SEL_LEDR: rd_data[9:0]  = ledr_q;
      SEL_LEDG: rd_data[7:0]  = ledg_q;
      SEL_KEY: begin
        rd_data[NUM_KEYS-1:0]              = db[NUM_KEYS-1:0];
        rd_data[KEY_STICKY_LSB +: NUM_KEYS] = sticky;
      end
      SEL_SW:   rd_data[NUM_SW-1:0] = db[NUM_INPUTS-1:NUM_KEYS];
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl with DEBOUNCE_CYCLES = 8.
// Works for both builds (IO_DEBOUNCE_EN defined or not).
module tb_mmio_io_ctrl;

  localparam int DB_N = 8;

  localparam logic [31:0] A_HEX  = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY  = 32'hF000_0010;
  localparam logic [31:0] A_SW   = 32'hF000_0014;

`ifdef IO_DEBOUNCE_EN
  localparam int SW_LAT = 2 + DB_N;
`else
  localparam int SW_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wr_data, rd_data;
  logic        wr_en, rd_en, io_hit;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [9:0]  ledr;
  logic [7:0]  ledg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mmio_io_ctrl #(.DEBOUNCE_CYCLES(DB_N)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data),
    .wr_en(wr_en), .rd_en(rd_en), .io_hit(io_hit), .rd_data(rd_data),
    .KEY(key), .SW(sw), .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .LEDR(ledr), .LEDG(ledg)
  );

  // Reference model, kept in "pressed / switch-up" terms: index 0..3 keys, 4..13 switches.
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;
  logic [3:0]  m_sticky;
  logic [13:0] m_s1, m_s2, m_db;
  int          m_run [14];

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic exp_hit(input logic [31:0] a);
    return (a == A_HEX) || (a == A_LEDR) || (a == A_LEDG) || (a == A_KEY) || (a == A_SW);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == A_HEX)  return {16'b0, m_hex};
    if (a == A_LEDR) return {22'b0, m_ledr};
    if (a == A_LEDG) return {24'b0, m_ledg};
    if (a == A_KEY)  return {24'b0, m_sticky, m_db[3:0]};
    if (a == A_SW)   return {22'b0, m_db[13:4]};
    return 32'h0;
  endfunction

  // Will debounced KEY[k] rise at the coming edge?
  function automatic logic will_rise(input int k);
`ifdef IO_DEBOUNCE_EN
    return m_s2[k] && !m_db[k] && (m_run[k] == DB_N - 1);
`else
    return m_s1[k] && !m_db[k];
`endif
  endfunction

  task automatic model_reset();
    m_hex = '0; m_ledr = '0; m_ledg = '0; m_sticky = '0;
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int i = 0; i < 14; i++) m_run[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [13:0] nd;
    if (reset) begin
      model_reset();
      return;
    end
    nd = m_db;
`ifdef IO_DEBOUNCE_EN
    for (int i = 0; i < 14; i++) begin
      if (m_s2[i] != m_db[i]) begin
        if (m_run[i] == DB_N - 1) begin
          nd[i] = m_s2[i];
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
`else
    nd = m_s1;
`endif
    m_sticky = ((rd_en && addr == A_KEY) ? 4'b0 : m_sticky) | (nd[3:0] & ~m_db[3:0]);
    if (wr_en && addr == A_HEX)  m_hex  = wr_data[15:0];
    if (wr_en && addr == A_LEDR) m_ledr = wr_data[9:0];
    if (wr_en && addr == A_LEDG) m_ledg = wr_data[7:0];
    m_s2 = m_s1;
    m_s1 = {sw, ~key};
    m_db = nd;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, compare all outputs against the model, clock, update model.
  task automatic step(input logic r, input logic [31:0] a, input logic we, input logic re,
                      input logic [31:0] wd);
    reset = r; addr = a; wr_en = we; rd_en = re; wr_data = wd;
    #1;
    check("io_hit",  {31'b0, io_hit}, {31'b0, exp_hit(a)});
    check("rd_data", rd_data, exp_rd(a));
    check("hex0", {25'b0, hex0}, {25'b0, seg(m_hex[3:0])});
    check("hex1", {25'b0, hex1}, {25'b0, seg(m_hex[7:4])});
    check("hex2", {25'b0, hex2}, {25'b0, seg(m_hex[11:8])});
    check("hex3", {25'b0, hex3}, {25'b0, seg(m_hex[15:12])});
    check("ledr", {22'b0, ledr}, {22'b0, m_ledr});
    check("ledg", {24'b0, ledg}, {24'b0, m_ledg});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Side-effect-free look at the read port with a fixed expected value.
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    reset = 1'b0; addr = a; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    logic [31:0] a;

    // 1. reset
    reset = 1'b1; addr = '0; wr_data = '0; wr_en = 1'b0; rd_en = 1'b0;
    key = 4'hF; sw = '0;
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_hex0", {25'b0, hex0}, 32'h40);
    check("rst_hex3", {25'b0, hex3}, 32'h40);
    check("rst_ledr", {22'b0, ledr}, 32'h0);
    check("rst_ledg", {24'b0, ledg}, 32'h0);
    peek("rst_key", A_KEY, 32'h0);
    peek("rst_sw",  A_SW,  32'h0);
    step(1'b0, A_KEY, 1'b0, 1'b0, '0);

    // 2. HEX store
    step(1'b0, A_HEX, 1'b1, 1'b0, 32'h0000_BEEF);
    #1;
    check("hex3_B", {25'b0, hex3}, 32'h03);
    check("hex2_E", {25'b0, hex2}, 32'h06);
    check("hex1_E", {25'b0, hex1}, 32'h06);
    check("hex0_F", {25'b0, hex0}, 32'h0E);
    peek("rd_hex", A_HEX, 32'h0000_BEEF);

    // 3. LED stores, ignored store to SW, store+load together reads pre-write value
    step(1'b0, A_LEDR, 1'b1, 1'b0, 32'hFFFF_FFFF);
    step(1'b0, A_LEDG, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, A_SW,   1'b1, 1'b0, 32'hFFFF_FFFF);
    #1;
    check("ledr_full", {22'b0, ledr}, 32'h3FF);
    check("ledg_full", {24'b0, ledg}, 32'hFF);
    peek("sw_unwritten", A_SW, 32'h0);

    // 4. short KEY[2] glitch, then a long press
    key = 4'b1011;
    repeat (5) step(1'b0, A_KEY, 1'b0, 1'b0, '0);
    key = 4'b1111;
    repeat (6) step(1'b0, A_KEY, 1'b0, 1'b0, '0);
`ifdef IO_DEBOUNCE_EN
    peek("glitch_key", A_KEY, 32'h00);
`else
    peek("glitch_key", A_KEY, 32'h40);
`endif
    key = 4'b1011;
    repeat (12) step(1'b0, A_KEY, 1'b0, 1'b0, '0);
    peek("press_key", A_KEY, 32'h44);
    key = 4'b1111;
    repeat (12) step(1'b0, A_KEY, 1'b0, 1'b0, '0);
    peek("release_key", A_KEY, 32'h40);

    // 5. KEY load on the same edge as a KEY[1] debounced rise
    key = 4'b1101;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (will_rise(1)) begin
        found = 1'b1;
        step(1'b0, A_KEY, 1'b0, 1'b1, '0);
      end else begin
        step(1'b0, A_KEY, 1'b0, 1'b0, '0);
      end
    end
    check("key1_rise_seen", {31'b0, found}, 32'h1);
    peek("set_wins", A_KEY, 32'h22);
    step(1'b0, A_KEY, 1'b0, 1'b1, '0);
    peek("sticky_cleared", A_KEY, 32'h02);
    key = 4'b1111;

    // 6. unmapped store, SW latency
    step(1'b0, 32'hF000_000C, 1'b1, 1'b1, 32'h1234_5678);
    step(1'b0, 32'hF000_000C, 1'b1, 1'b0, 32'h0000_0000);
    peek("hole_hex", A_HEX, 32'h0000_BEEF);
    sw = 10'h2A5;
    repeat (SW_LAT - 1) step(1'b0, A_SW, 1'b0, 1'b0, '0);
    peek("sw_early", A_SW, 32'h0);
    step(1'b0, A_SW, 1'b0, 1'b0, '0);
    peek("sw_late", A_SW, 32'h2A5);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(7))
        0: a = A_HEX;
        1: a = A_LEDR;
        2: a = A_LEDG;
        3: a = A_KEY;
        4: a = A_SW;
        5: a = 32'hF000_000C;
        6: a = 32'hF000_0018;
        default: a = $urandom;
      endcase
      if ($urandom_range(15) == 0) key = key ^ 4'(1 << $urandom_range(3));
      if ($urandom_range(15) == 0) sw  = sw ^ 10'(1 << $urandom_range(9));
      step(($urandom_range(49) == 0), a, ($urandom_range(1) == 0),
           ($urandom_range(2) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
